sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
Single-clock, parametrised FIFO buffer for symbol/sample streams between stages of the QAM modulator datapath.
- Generalises the fixed 4-entry, 8-bit FIFO memory to configurable width and depth.
- Adds full/empty/almost-full/almost-empty status, an occupancy count, sticky overflow/underflow error flags and a selectable first-word-fall-through (FWFT) read mode.

Parameters:
DATA_WIDTH, 8, width of each stored word
DEPTH, 16, number of entries; power of two, >= 4
ALMOST_FULL_THRESH, 14, almost_full asserted when fill_count >= this; range 1..DEPTH
ALMOST_EMPTY_THRESH, 2, almost_empty asserted when fill_count <= this; range 0..DEPTH-1
FWFT, 0, 0 = registered read (1-cycle latency); 1 = first-word-fall-through

Ports:
clk  input  1  single clock; all state updates on posedge
reset  input  1  asynchronous, active-high reset
write_enable  input  1  push request
data_in  input  DATA_WIDTH  word to push
read_enable  input  1  pop request
data_out  output  DATA_WIDTH  read data
data_valid  output  1  data_out holds valid data (see Behaviour)
full  output  1  fill_count == DEPTH
empty  output  1  fill_count == 0
almost_full  output  1  fill_count >= ALMOST_FULL_THRESH
almost_empty  output  1  fill_count <= ALMOST_EMPTY_THRESH
fill_count  output  log2(DEPTH)+1  current occupancy, 0..DEPTH
clear_errors  input  1  clears overflow/underflow
overflow  output  1  sticky: write attempted while full
underflow  output  1  sticky: read attempted while empty

Behaviour:
- Clock and reset: single clock `clk`; `reset` is asynchronous and active-high.
- Reset values:
  - Write and read pointers = 0; fill_count = 0.
  - empty = 1, full = 0, almost_empty = 1, almost_full = 0.
  - data_out = 0, data_valid = 0, overflow = 0, underflow = 0.
  - Memory contents are not reset.
- Pointers:
  - Write and read pointers are log2(DEPTH)+1 bits; the MSB is the wrap bit.
  - The address is the low log2(DEPTH) bits. Pointers wrap naturally modulo 2*DEPTH.
- Accept rules, evaluated on registered flags:
  - Write is accepted iff write_enable & !full.
  - Read is accepted iff read_enable & !empty.
- Simultaneous read and write:
  - Both accepted: count unchanged, both pointers advance.
  - When full: read accepted, write rejected, overflow set.
  - When empty: write accepted, read rejected, underflow set.
- Status timing:
  - fill_count and all flags are registered and reflect the state after this cycle's accepted operations, visible on the next cycle.
  - fill_count = wr_ptr - rd_ptr (modulo 2*DEPTH).
- Registered read mode (FWFT=0):
  - An accepted read loads mem[rd_addr] into data_out at the same edge.
  - data_valid pulses high for exactly the following cycle.
  - data_out holds its value when no read is accepted.
- FWFT mode (FWFT=1):
  - data_out continuously presents the head word mem[rd_addr]; data_valid = !empty.
  - read_enable acts as an acknowledge/pop.
  - A word written into an empty FIFO appears on data_out with data_valid=1 one cycle after the write edge.
- Error flags:
  - overflow sets on write_enable & full; underflow sets on read_enable & empty.
  - clear_errors clears both. A set in the same cycle as clear_errors wins.
  - Rejected operations never modify pointers or memory.
- Wrap-around: after 2*DEPTH pushes/pops, pointers return to 0 with no glitch on flags.
- Reset mid-operation: all state returns to the reset values immediately. The in-flight word is discarded; data_valid drops to 0.
- Illegal parameters (DEPTH not a power of two, thresholds out of range) are stopped by an elaboration-time check.

Decomposition:
- Shared package fifo_pkg:
  - default DATA_WIDTH and DEPTH constants;
  - an address-width function (ceil log2);
  - FWFT mode constants FIFO_MODE_STD=0 and FIFO_MODE_FWFT=1.
- One sub-module, sync_fifo_ram:
  - single-clock dual-port array;
  - synchronous write port and asynchronous read port, parametrised by DATA_WIDTH and DEPTH.
  - The top level holds the pointers, flags, count, errors and the output register.

Test Plan:
- Reset, FWFT=0, DEPTH=16: write 0x01..0x10 on consecutive cycles -> full=1 after the 16th edge, fill_count=16, almost_full=1 from count 14. Then read 16 -> data_out 0x01..0x10 in order, each with a 1-cycle data_valid pulse; empty=1 at the end.
- Full FIFO, write_enable=1 with data 0xAA -> overflow=1 and fill_count stays 16; a subsequent read returns 0x01, not 0xAA. Pulse clear_errors -> overflow=0.
- Empty FIFO, read_enable=1 -> underflow=1, data_valid stays 0, data_out unchanged. Simultaneous write 0x55 and read on empty -> fill_count=1, underflow=1.
- Steady stream with write and read both high for 40 cycles at fill_count=8 -> fill_count constant at 8, pointers wrap twice, output order preserved.
- FWFT=1: write 0x3C into an empty FIFO -> the next cycle gives data_out=0x3C, data_valid=1. Pop -> empty=1, data_valid=0 on the following cycle.
- Assert reset asynchronously mid-cycle with 5 entries stored -> all outputs return to reset values immediately. The next write/read pair returns the new word, not stale data.

Source files
------------

// File: rtl/fifo_pkg.sv
// +--------------------------------------------------------------------------+
// | fifo_pkg : shared constants and helpers for the parametrised sync FIFO    |
// | rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

package fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_DEPTH      = 16;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  function automatic int addr_width(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo_ram.sv
// +--------------------------------------------------------------------------+
// | sync_fifo_ram : storage array, synchronous write / asynchronous read      |
// | rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module sync_fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int AW         = addr_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  // Contents are deliberately left unreset so the array maps onto RAM.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

`default_nettype wire

// File: rtl/sync_fifo_param.sv
// +--------------------------------------------------------------------------+
// | sync_fifo_param : single-clock FIFO with status, errors and FWFT option   |
// | rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH          = DEFAULT_DATA_WIDTH,
  parameter int DEPTH               = DEFAULT_DEPTH,
  parameter int ALMOST_FULL_THRESH  = 14,
  parameter int ALMOST_EMPTY_THRESH = 2,
  parameter int FWFT                = FIFO_MODE_STD
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       write_enable,
  input  logic [DATA_WIDTH-1:0]      data_in,
  input  logic                       read_enable,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic                       data_valid,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [addr_width(DEPTH):0] fill_count,
  input  logic                       clear_errors,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = addr_width(DEPTH);
  localparam int CW = AW + 1;

  generate
    if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("sync_fifo_param: DEPTH must be a power of two and >= 4");
    end
    if ((ALMOST_FULL_THRESH < 1) || (ALMOST_FULL_THRESH > DEPTH)) begin : g_bad_af
      $error("sync_fifo_param: ALMOST_FULL_THRESH out of range");
    end
    if ((ALMOST_EMPTY_THRESH < 0) || (ALMOST_EMPTY_THRESH > DEPTH - 1)) begin : g_bad_ae
      $error("sync_fifo_param: ALMOST_EMPTY_THRESH out of range");
    end
    if ((FWFT != FIFO_MODE_STD) && (FWFT != FIFO_MODE_FWFT)) begin : g_bad_mode
      $error("sync_fifo_param: FWFT must be 0 or 1");
    end
  endgenerate

  logic [CW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         wr_ptr_nxt, rd_ptr_nxt, count_nxt;
  logic                  wr_accept, rd_accept;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Accept decisions use the registered flags only, never the live count.
  assign wr_accept  = write_enable & ~full;
  assign rd_accept  = read_enable & ~empty;
  assign wr_ptr_nxt = wr_ptr + CW'(wr_accept);
  assign rd_ptr_nxt = rd_ptr + CW'(rd_accept);
  assign count_nxt  = wr_ptr_nxt - rd_ptr_nxt;

  sync_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_accept),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (data_in),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (ram_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fill_count   <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr_nxt;
      rd_ptr       <= rd_ptr_nxt;
      fill_count   <= count_nxt;
      full         <= (count_nxt == CW'(DEPTH));
      empty        <= (count_nxt == '0);
      almost_full  <= (count_nxt >= CW'(ALMOST_FULL_THRESH));
      almost_empty <= (count_nxt <= CW'(ALMOST_EMPTY_THRESH));
      // A new error in the same cycle as clear_errors must survive the clear.
      overflow     <= (write_enable & full) | (overflow & ~clear_errors);
      underflow    <= (read_enable & empty) | (underflow & ~clear_errors);
    end
  end

  generate
    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      assign data_out   = empty ? '0 : ram_rdata;
      assign data_valid = ~empty;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] dout_q;
      logic                  valid_q;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          dout_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          valid_q <= rd_accept;
          if (rd_accept) dout_q <= ram_rdata;
        end
      end

      assign data_out   = dout_q;
      assign data_valid = valid_q;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: one registered-read and one FWFT instance share
// directed stimulus and are checked every cycle against a queue-based model.
`default_nettype none

module tb_sync_fifo_param;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AFT   = 14;
  localparam int AET   = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          we = 1'b0, re = 1'b0, clr = 1'b0;
  logic [DW-1:0] din = '0;

  logic [DW-1:0] dout_s, dout_f;
  logic          valid_s, valid_f, full_s, full_f, empty_s, empty_f;
  logic          af_s, af_f, ae_s, ae_f, ovf_s, ovf_f, unf_s, unf_f;
  logic [4:0]    cnt_s, cnt_f;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ALMOST_FULL_THRESH(AFT),
                    .ALMOST_EMPTY_THRESH(AET), .FWFT(0)) u_std (
    .clk(clk), .reset(reset), .write_enable(we), .data_in(din), .read_enable(re),
    .data_out(dout_s), .data_valid(valid_s), .full(full_s), .empty(empty_s),
    .almost_full(af_s), .almost_empty(ae_s), .fill_count(cnt_s),
    .clear_errors(clr), .overflow(ovf_s), .underflow(unf_s));

  sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ALMOST_FULL_THRESH(AFT),
                    .ALMOST_EMPTY_THRESH(AET), .FWFT(1)) u_fwft (
    .clk(clk), .reset(reset), .write_enable(we), .data_in(din), .read_enable(re),
    .data_out(dout_f), .data_valid(valid_f), .full(full_f), .empty(empty_f),
    .almost_full(af_f), .almost_empty(ae_f), .fill_count(cnt_f),
    .clear_errors(clr), .overflow(ovf_f), .underflow(unf_f));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of stored words plus sticky error bits.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout;
  logic          m_valid, m_ovf, m_unf;
  int            m_n;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      m_dout = '0; m_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      m_n     = q.size();
      m_ovf   = (we && m_n == DEPTH) || (m_ovf && !clr);
      m_unf   = (re && m_n == 0) || (m_unf && !clr);
      m_valid = re && m_n > 0;
      if (m_valid) m_dout = q.pop_front();
      if (we && m_n < DEPTH) q.push_back(din);
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("std_count", 32'(cnt_s), q.size());
      chk("std_full", 32'(full_s), 32'(q.size() == DEPTH));
      chk("std_empty", 32'(empty_s), 32'(q.size() == 0));
      chk("std_afull", 32'(af_s), 32'(q.size() >= AFT));
      chk("std_aempty", 32'(ae_s), 32'(q.size() <= AET));
      chk("std_ovf", 32'(ovf_s), 32'(m_ovf));
      chk("std_unf", 32'(unf_s), 32'(m_unf));
      chk("std_valid", 32'(valid_s), 32'(m_valid));
      chk("std_dout", 32'(dout_s), 32'(m_dout));
      chk("fwft_count", 32'(cnt_f), q.size());
      chk("fwft_ovf", 32'(ovf_f), 32'(m_ovf));
      chk("fwft_unf", 32'(unf_f), 32'(m_unf));
      chk("fwft_valid", 32'(valid_f), 32'(q.size() != 0));
      chk("fwft_dout", 32'(dout_f), (q.size() != 0) ? 32'(q[0]) : 32'h0);
    end
  end

  // Inputs change 2 time units after the edge, well away from sampling.
  task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
    we = w; din = d; re = r; clr = c;
    @(posedge clk);
    #2;
    we = 1'b0; re = 1'b0; clr = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #7 reset = 1'b0;
    chk("rst_count", 32'(cnt_s), 32'd0);
    chk("rst_empty", 32'(empty_s), 32'd1);
    chk("rst_aempty", 32'(ae_s), 32'd1);
    chk("rst_full", 32'(full_s), 32'd0);
    chk("rst_dout", 32'(dout_s), 32'd0);
    chk("rst_valid", 32'(valid_s), 32'd0);
    @(posedge clk); #2;

    // Fill with 0x01..0x10, pinning the almost_full threshold.
    for (int i = 1; i <= DEPTH; i++) begin
      cyc(1'b1, DW'(i), 1'b0, 1'b0);
      if (i == 13) chk("af_at13", 32'(af_s), 32'd0);
      if (i == 14) chk("af_at14", 32'(af_s), 32'd1);
    end
    chk("fill_full", 32'(full_s), 32'd1);
    chk("fill_count16", 32'(cnt_s), 32'd16);

    cyc(1'b1, 8'hAA, 1'b0, 1'b0);
    chk("ovf_set", 32'(ovf_s), 32'd1);
    chk("ovf_count", 32'(cnt_s), 32'd16);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("first_read", 32'(dout_s), 32'h01);
    chk("first_valid", 32'(valid_s), 32'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_clear", 32'(ovf_s), 32'd0);
    chk("valid_pulse", 32'(valid_s), 32'd0);
    for (int i = 2; i <= DEPTH; i++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("drain_data", 32'(dout_s), 32'(i));
    end
    chk("drain_empty", 32'(empty_s), 32'd1);

    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("unf_set", 32'(unf_s), 32'd1);
    chk("unf_valid", 32'(valid_s), 32'd0);
    chk("unf_dout", 32'(dout_s), 32'h10);
    cyc(1'b1, 8'h55, 1'b1, 1'b0);
    chk("wr_rd_empty_cnt", 32'(cnt_s), 32'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);

    // Bring occupancy to 8, then stream 40 simultaneous push/pops.
    for (int i = 0; i < 7; i++) cyc(1'b1, DW'(8'h60 + i), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) cyc(1'b1, DW'(8'h70 + i), 1'b1, 1'b0);
    chk("stream_count", 32'(cnt_s), 32'd8);
    chk("stream_last", 32'(dout_s), 32'h8F);
    for (int i = 0; i < 8; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("stream_drained", 32'(dout_s), 32'h97);

    cyc(1'b1, 8'h3C, 1'b0, 1'b0);
    chk("fwft_head", 32'(dout_f), 32'h3C);
    chk("fwft_head_valid", 32'(valid_f), 32'd1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("fwft_pop_empty", 32'(empty_f), 32'd1);
    chk("fwft_pop_valid", 32'(valid_f), 32'd0);

    // Five stored words, then an asynchronous reset mid-cycle.
    for (int i = 0; i < 5; i++) cyc(1'b1, DW'(8'h81 + i), 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    #1 reset = 1'b1;
    #1;
    chk("arst_count", 32'(cnt_s), 32'd0);
    chk("arst_empty", 32'(empty_s), 32'd1);
    chk("arst_valid", 32'(valid_s), 32'd0);
    chk("arst_dout", 32'(dout_s), 32'd0);
    chk("arst_fwft_valid", 32'(valid_f), 32'd0);
    chk("arst_fwft_count", 32'(cnt_f), 32'd0);
    #3 reset = 1'b0;
    @(posedge clk); #2;
    cyc(1'b1, 8'h99, 1'b0, 1'b0);
    chk("post_rst_fwft", 32'(dout_f), 32'h99);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("post_rst_read", 32'(dout_s), 32'h99);
    chk("post_rst_empty", 32'(empty_s), 32'd1);
    @(posedge clk); #2;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
